// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial sequence detector (MSB-first pattern, KMP fallback,
// optional overlap). Define MOORE_SEQ_DETECTOR_COUNT_EN to build the match counter.
module moore_seq_detector #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int                 OVERLAP = 0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             en,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int SW = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] ST_MATCH = SW'(PAT_LEN);

    // Flattened transition table indexed by {state, input bit}.
    typedef logic [2*PAT_LEN+1:0][SW-1:0] tbl_t;

    // Pattern bit in arrival order: idx 0 is the first bit expected on the wire.
    function automatic logic f_pat_bit(input int idx);
        logic [31:0] v;
        v = 32'(PATTERN) >> (PAT_LEN - 1 - idx);
        return v[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length s) followed by b.
    function automatic int f_delta(input int s, input logic b);
        int   res;
        int   pos;
        logic ok;
        logic e;
        res = 0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    pos = s + 1 - k + i;
                    e   = (pos < s) ? f_pat_bit(pos) : b;
                    if (e != f_pat_bit(i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    // Longest proper border of the whole pattern, used to resume after a match.
    function automatic int f_border();
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (f_pat_bit(i) != f_pat_bit(PAT_LEN - k + i)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = k;
            end
        end
        return res;
    endfunction

    function automatic tbl_t f_build_tbl();
        tbl_t t;
        int   base;
        for (int s = 0; s <= PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                if (s == PAT_LEN) begin
                    base = (OVERLAP != 0) ? f_border() : 0;
                end else begin
                    base = s;
                end
                t[2*s+b] = SW'(f_delta(base, (b != 0)));
            end
        end
        return t;
    endfunction

    localparam tbl_t NXT_TBL = f_build_tbl();

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_state_nxt;

    // State register; R discards any partial match.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= {SW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state lookup; an out-of-range state recovers to the idle state.
    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            if (r_state <= ST_MATCH) begin
                w_state_nxt = NXT_TBL[{r_state, in}];
            end else begin
                w_state_nxt = {SW{1'b0}};
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Moore output decoded from the state register only.
    always_comb begin
        out = (r_state == ST_MATCH);
    end

`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of edges that land in MATCH.
    always_ff @(posedge clk) begin
        if (R) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (en && (w_state_nxt == ST_MATCH) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench for moore_seq_detector: six parameterisations share the
// stimulus; a sliding-window reference model feeds a per-cycle scoreboard.
module tb_moore_seq_detector;

`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
    localparam bit COUNT_ON = 1'b1;
`else
    localparam bit COUNT_ON = 1'b0;
`endif

    logic clk;
    logic R;
    logic en;
    logic din;

    logic out0, out1, out2, out3, out4, out5;
    logic [7:0] cnt0, cnt1, cnt2, cnt3, cnt4;
    logic [1:0] cnt5;

    int total;
    int bad;

    logic [8:0] sb[$];

    int          m_len;
    logic [31:0] m_pat;
    bit          m_ovl;
    int          m_max;
    logic [31:0] m_hist;
    int          m_nbits;
    int          m_since;
    logic        m_out;
    int          m_cnt;

    moore_seq_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) d0 (
        .clk(clk), .R(R), .en(en), .in(din), .out(out0), .match_cnt(cnt0));
    moore_seq_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) d1 (
        .clk(clk), .R(R), .en(en), .in(din), .out(out1), .match_cnt(cnt1));
    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) d2 (
        .clk(clk), .R(R), .en(en), .in(din), .out(out2), .match_cnt(cnt2));
    moore_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(8)) d3 (
        .clk(clk), .R(R), .en(en), .in(din), .out(out3), .match_cnt(cnt3));
    moore_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(0), .CNT_W(8)) d4 (
        .clk(clk), .R(R), .en(en), .in(din), .out(out4), .match_cnt(cnt4));
    moore_seq_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2)) d5 (
        .clk(clk), .R(R), .en(en), .in(din), .out(out5), .match_cnt(cnt5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    function automatic logic [8:0] obs(input int sel);
        case (sel)
            0: return {out0, cnt0};
            1: return {out1, cnt1};
            2: return {out2, cnt2};
            3: return {out3, cnt3};
            4: return {out4, cnt4};
            5: return {out5, 6'd0, cnt5};
            default: return 9'h1ff;
        endcase
    endfunction

    task automatic set_model(input int len, input logic [31:0] pat, input bit ovl, input int cmax);
        m_len = len; m_pat = pat; m_ovl = ovl; m_max = cmax;
        m_hist = 32'd0; m_nbits = 0; m_since = 0; m_out = 1'b0; m_cnt = 0;
    endtask

    // Step code {R, en, in}: drive it, advance the model, queue the expectation.
    task automatic drive(input logic [2:0] st);
        logic [31:0] mask;
        @(negedge clk);
        R = st[2]; en = st[1]; din = st[0];
        mask = (32'd1 << m_len) - 32'd1;
        if (st[2]) begin
            m_hist = 32'd0; m_nbits = 0; m_since = 0; m_out = 1'b0; m_cnt = 0;
        end else if (st[1]) begin
            m_hist = {m_hist[30:0], st[0]};
            m_nbits++;
            m_since++;
            if (((m_hist & mask) == m_pat) && (m_ovl ? (m_nbits >= m_len) : (m_since >= m_len))) begin
                m_out = 1'b1;
                m_since = 0;
                if (m_cnt < m_max) m_cnt++;
            end else begin
                m_out = 1'b0;
            end
        end
        sb.push_back({m_out, (COUNT_ON ? m_cnt[7:0] : 8'd0)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] st [0:6];
        logic [8:0] got, exp;
        int pulses;
        st = '{3'b111, 3'b110, 3'b111, 3'b011, 3'b010, 3'b011, 3'b010};
        set_model(3, 32'b101, 1'b0, 255);
        pulses = 0;
        foreach (st[i]) begin
            drive(st[i]);
            got = obs(0);
            exp = sb.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, got[8], got[7:0], exp[8], exp[7:0]);
            end
            if (got[8] === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL reset_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_overlap();
        logic [2:0] st [0:5];
        logic [8:0] got, exp;
        int pulses;
        st = '{3'b110, 3'b011, 3'b010, 3'b011, 3'b010, 3'b011};
        for (int sel = 0; sel < 2; sel++) begin
            set_model(3, 32'b101, (sel == 1), 255);
            pulses = 0;
            foreach (st[i]) begin
                drive(st[i]);
                got = obs(sel);
                exp = sb.pop_front();
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL overlap%0d step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d",
                             sel, i, got[8], got[7:0], exp[8], exp[7:0]);
                end
                if (got[8] === 1'b1) pulses++;
            end
            total++;
            if (pulses != sel + 1) begin
                bad++;
                $display("FAIL overlap%0d_pulses: got %0d, want %0d", sel, pulses, sel + 1);
            end
        end
    endtask

    task automatic test_kmp();
        logic [2:0] st [0:5];
        logic [8:0] got, exp;
        int first;
        st = '{3'b110, 3'b011, 3'b011, 3'b011, 3'b010, 3'b011};
        set_model(4, 32'b1101, 1'b0, 255);
        first = -1;
        foreach (st[i]) begin
            drive(st[i]);
            got = obs(2);
            exp = sb.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL kmp step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, got[8], got[7:0], exp[8], exp[7:0]);
            end
            if ((got[8] === 1'b1) && (first < 0)) first = i;
        end
        total++;
        if (first != 5) begin
            bad++;
            $display("FAIL kmp_first_pulse: got step %0d, want step 5", first);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] st [0:4];
        logic [8:0] got, exp;
        int pulses;
        int want;
        st = '{3'b110, 3'b011, 3'b011, 3'b011, 3'b011};
        for (int sel = 3; sel < 5; sel++) begin
            set_model(2, 32'b11, (sel == 3), 255);
            pulses = 0;
            want = (sel == 3) ? 3 : 2;
            foreach (st[i]) begin
                drive(st[i]);
                got = obs(sel);
                exp = sb.pop_front();
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL b2b_d%0d step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d",
                             sel, i, got[8], got[7:0], exp[8], exp[7:0]);
                end
                if (got[8] === 1'b1) pulses++;
            end
            total++;
            if (pulses != want) begin
                bad++;
                $display("FAIL b2b_d%0d_pulses: got %0d, want %0d", sel, pulses, want);
            end
        end
    endtask

    task automatic test_enable();
        logic [2:0] st [0:17];
        logic [8:0] got, exp;
        int pulses;
        // en-hold run, R-interrupted run, then en=0 while sitting in MATCH
        st = '{3'b110, 3'b011, 3'b010, 3'b000, 3'b000, 3'b011,
               3'b110, 3'b011, 3'b010, 3'b110, 3'b011,
               3'b110, 3'b011, 3'b010, 3'b011, 3'b000, 3'b000, 3'b010};
        set_model(3, 32'b101, 1'b0, 255);
        pulses = 0;
        foreach (st[i]) begin
            drive(st[i]);
            got = obs(0);
            exp = sb.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL enable step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, got[8], got[7:0], exp[8], exp[7:0]);
            end
            if ((got[8] === 1'b1) && (i <= 10)) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL enable_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] st [0:11];
        logic [8:0] got, exp;
        int pulses;
        st = '{3'b110, 3'b011, 3'b010, 3'b011, 3'b010, 3'b011, 3'b010,
               3'b011, 3'b010, 3'b011, 3'b010, 3'b011};
        set_model(3, 32'b101, 1'b1, 3);
        pulses = 0;
        got = 9'd0;
        foreach (st[i]) begin
            drive(st[i]);
            got = obs(5);
            exp = sb.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL saturation step %0d: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, got[8], got[7:0], exp[8], exp[7:0]);
            end
            if (got[8] === 1'b1) pulses++;
        end
        total++;
        if (pulses != 5) begin
            bad++;
            $display("FAIL saturation_pulses: got %0d, want 5", pulses);
        end
        total++;
        if (got[7:0] !== (COUNT_ON ? 8'd3 : 8'd0)) begin
            bad++;
            $display("FAIL saturation_final_cnt: got %0d, want %0d", got[7:0], (COUNT_ON ? 3 : 0));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        R = 1'b1;
        en = 1'b0;
        din = 1'b0;
        test_reset();
        test_overlap();
        test_kmp();
        test_back_to_back();
        test_enable();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
